// File: rtl/iob_axis2ahb_sched_if.sv
// iob_axis2ahb_sched_if: request, stream and adapter-side signals of the two-channel scheduler.
// The master modport is the scheduler's view; slave is the surrounding environment's view.
interface iob_axis2ahb_sched_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
);
  logic [1:0]          req_valid_i, req_ready_o, req_write_i, done_o;
  logic [2*ADDR_W-1:0] req_addr_i;
  logic [2*LEN_W-1:0]  req_len_i;
  logic [2*DATA_W-1:0] s_axis_tdata_i;
  logic [1:0]          s_axis_tvalid_i, s_axis_tready_o;
  logic [DATA_W-1:0]   m_axis_tdata_o;
  logic [1:0]          m_axis_tvalid_o, m_axis_tready_i;
  logic                m_axis_tlast_o;
  logic                cfg_in_valid_o, cfg_in_ready_i;
  logic [ADDR_W-1:0]   cfg_in_addr_o;
  logic                cfg_out_valid_o, cfg_out_ready_i;
  logic [ADDR_W-1:0]   cfg_out_addr_o, cfg_out_length_o;
  logic [DATA_W-1:0]   ad_in_tdata_o;
  logic                ad_in_tvalid_o, ad_in_tlast_o, ad_in_tready_i;
  logic [DATA_W-1:0]   ad_out_tdata_i;
  logic                ad_out_tvalid_i, ad_out_tready_o;
  modport master (
    input  req_valid_i, req_write_i, req_addr_i, req_len_i, s_axis_tdata_i, s_axis_tvalid_i,
           m_axis_tready_i, cfg_in_ready_i, cfg_out_ready_i, ad_in_tready_i, ad_out_tdata_i, ad_out_tvalid_i,
    output req_ready_o, done_o, s_axis_tready_o, m_axis_tdata_o, m_axis_tvalid_o, m_axis_tlast_o,
           cfg_in_valid_o, cfg_in_addr_o, cfg_out_valid_o, cfg_out_addr_o, cfg_out_length_o,
           ad_in_tdata_o, ad_in_tvalid_o, ad_in_tlast_o, ad_out_tready_o
  );
  modport slave (
    output req_valid_i, req_write_i, req_addr_i, req_len_i, s_axis_tdata_i, s_axis_tvalid_i,
           m_axis_tready_i, cfg_in_ready_i, cfg_out_ready_i, ad_in_tready_i, ad_out_tdata_i, ad_out_tvalid_i,
    input  req_ready_o, done_o, s_axis_tready_o, m_axis_tdata_o, m_axis_tvalid_o, m_axis_tlast_o,
           cfg_in_valid_o, cfg_in_addr_o, cfg_out_valid_o, cfg_out_addr_o, cfg_out_length_o,
           ad_in_tdata_o, ad_in_tvalid_o, ad_in_tlast_o, ad_out_tready_o
  );
endinterface

// File: rtl/iob_axis2ahb_sched.sv
// iob_axis2ahb_sched: round-robin two-channel scheduler that splits requests into AHB-legal
// chunks (<= MAX_BURST beats, no 1 KB crossing) and steers the granted channel's streams.
module iob_axis2ahb_sched #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 16,
  parameter int MAX_BURST = 16
) (
  input logic clk_i,
  input logic cke_i,
  input logic rst_n_i,
  iob_axis2ahb_sched_if.master bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int BL    = $clog2(BYTES);
  localparam int W     = LEN_W > 11 ? LEN_W : 11;
  localparam int CW    = $clog2(MAX_BURST) + 1;
  typedef enum logic [2:0] {IDLE, ISSUE, WDATA, RDATA, NEXT, DONE} state_t;
  state_t            state_q, state_d;
  logic              rr_q, rr_d, gnt_q, gnt_d, wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [W-1:0]      bnd, lim, chunk;
  logic [1:0]        oh;
  logic              g, cfg_hs, w_hs, r_hs, idle, iss, in_w, in_r;
  // beats left before the next 1 KB boundary, then clipped by burst limit and remaining length
  assign bnd   = W'((11'd1024 - {1'b0, addr_q[9:0]}) >> BL);
  assign lim   = bnd < W'(MAX_BURST) ? bnd : W'(MAX_BURST);
  assign chunk = W'(rem_q) < lim ? W'(rem_q) : lim;
  assign g      = bus.req_valid_i[rr_q] ? rr_q : ~rr_q;
  assign oh     = {gnt_q, ~gnt_q};
  assign idle   = state_q == IDLE;
  assign iss    = state_q == ISSUE;
  assign in_w   = state_q == WDATA;
  assign in_r   = state_q == RDATA;
  assign cfg_hs = wr_q ? bus.cfg_in_ready_i : bus.cfg_out_ready_i;
  assign w_hs   = bus.s_axis_tvalid_i[gnt_q] & bus.ad_in_tready_i;
  assign r_hs   = bus.ad_out_tvalid_i & bus.m_axis_tready_i[gnt_q];
  // handshake-side outputs are masked by cke_i so no transfer completes while state is frozen
  assign bus.req_ready_o      = (idle && cke_i) ? bus.req_valid_i & {g, ~g} : 2'b00;
  assign bus.done_o           = state_q == DONE ? oh : 2'b00;
  assign bus.cfg_in_valid_o   = iss & wr_q & cke_i;
  assign bus.cfg_in_addr_o    = (iss && wr_q) ? addr_q : '0;
  assign bus.cfg_out_valid_o  = iss & ~wr_q & cke_i;
  assign bus.cfg_out_addr_o   = (iss && !wr_q) ? addr_q : '0;
  assign bus.cfg_out_length_o = (iss && !wr_q) ? ADDR_W'(chunk - W'(1)) : '0;
  assign bus.ad_in_tdata_o    = in_w ? bus.s_axis_tdata_i[gnt_q*DATA_W +: DATA_W] : '0;
  assign bus.ad_in_tvalid_o   = in_w & cke_i & bus.s_axis_tvalid_i[gnt_q];
  assign bus.ad_in_tlast_o    = in_w && cnt_q == CW'(1);
  assign bus.s_axis_tready_o  = (in_w && cke_i) ? oh & {2{bus.ad_in_tready_i}} : 2'b00;
  assign bus.m_axis_tdata_o   = in_r ? bus.ad_out_tdata_i : '0;
  assign bus.m_axis_tvalid_o  = (in_r && cke_i) ? oh & {2{bus.ad_out_tvalid_i}} : 2'b00;
  assign bus.ad_out_tready_o  = in_r & cke_i & bus.m_axis_tready_i[gnt_q];
  assign bus.m_axis_tlast_o   = in_r && cnt_q == CW'(1) && W'(rem_q) == chunk;
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (|bus.req_valid_i) begin
        gnt_d   = g;
        rr_d    = ~g;
        wr_d    = bus.req_write_i[g];
        addr_d  = bus.req_addr_i[g*ADDR_W +: ADDR_W] & ~ADDR_W'(BYTES - 1);
        rem_d   = bus.req_len_i[g*LEN_W +: LEN_W];
        state_d = rem_d == '0 ? DONE : ISSUE;
      end
      ISSUE: if (cfg_hs) begin
        cnt_d   = CW'(chunk);
        state_d = wr_q ? WDATA : RDATA;
      end
      WDATA, RDATA: if (wr_q ? w_hs : r_hs) begin
        cnt_d   = cnt_q - CW'(1);
        state_d = cnt_q == CW'(1) ? NEXT : state_q;
      end
      NEXT: begin
        addr_d  = addr_q + (ADDR_W'(chunk) << BL);
        rem_d   = rem_q - LEN_W'(chunk);
        state_d = rem_d == '0 ? DONE : ISSUE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (!rst_n_i) begin
        state_q <= IDLE;
        rr_q    <= 1'b0;
        gnt_q   <= 1'b0;
        wr_q    <= 1'b0;
        addr_q  <= '0;
        rem_q   <= '0;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        rr_q    <= rr_d;
        gnt_q   <= gnt_d;
        wr_q    <= wr_d;
        addr_q  <= addr_d;
        rem_q   <= rem_d;
        cnt_q   <= cnt_d;
      end
    end
  end
endmodule

// File: tb/tb_iob_axis2ahb_sched.sv
// tb_iob_axis2ahb_sched: directed scenarios with hand-computed expectations for the scheduler.
module tb_iob_axis2ahb_sched;
  logic clk, cke, rst_n;
  int   n_cmp, n_bad;
  iob_axis2ahb_sched_if bus();
  iob_axis2ahb_sched dut (.clk_i(clk), .cke_i(cke), .rst_n_i(rst_n), .bus(bus));
  logic [173:0] all_out;
  assign all_out = {bus.req_ready_o, bus.done_o, bus.s_axis_tready_o, bus.m_axis_tvalid_o, bus.m_axis_tlast_o,
                    bus.cfg_in_valid_o, bus.cfg_out_valid_o, bus.ad_in_tvalid_o, bus.ad_in_tlast_o,
                    bus.ad_out_tready_o, bus.cfg_in_addr_o, bus.cfg_out_addr_o, bus.cfg_out_length_o,
                    bus.ad_in_tdata_o, bus.m_axis_tdata_o};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clear_inputs;
    bus.req_valid_i = '0; bus.req_write_i = '0; bus.req_addr_i = '0; bus.req_len_i = '0;
    bus.s_axis_tdata_i = '0; bus.s_axis_tvalid_i = '0; bus.m_axis_tready_i = '0;
    bus.cfg_in_ready_i = 1'b0; bus.cfg_out_ready_i = 1'b0; bus.ad_in_tready_i = 1'b0;
    bus.ad_out_tdata_i = '0; bus.ad_out_tvalid_i = 1'b0;
  endtask
  task automatic request(input int c, input bit w, input logic [31:0] a, input logic [15:0] l);
    bus.req_valid_i[c] = 1'b1;
    bus.req_write_i[c] = w;
    bus.req_addr_i[c*32 +: 32] = a;
    bus.req_len_i[c*16 +: 16] = l;
  endtask
  task automatic test_reset;
    clear_inputs();
    cke = 1'b1; rst_n = 1'b0;
    tick(); tick();
    #2;
    n_cmp++; if (all_out !== '0) begin n_bad++; $display("FAIL reset_outputs got=%0h exp=0", all_out); end
    rst_n = 1'b1;
    tick();
    #2;
    n_cmp++; if (all_out !== '0) begin n_bad++; $display("FAIL idle_outputs got=%0h exp=0", all_out); end
  endtask
  task automatic test_cke_hold;
    cke = 1'b0;
    request(1, 1'b1, 32'h0, 16'd3);
    tick();
    #2;
    n_cmp++; if (bus.req_ready_o !== 2'b00) begin n_bad++; $display("FAIL cke_ready got=%b exp=00", bus.req_ready_o); end
    cke = 1'b1;
    #1;
    n_cmp++; if (bus.req_ready_o !== 2'b10) begin n_bad++; $display("FAIL cke_resume_ready got=%b exp=10", bus.req_ready_o); end
    bus.req_valid_i = '0;
    #1;
  endtask
  task automatic test_write_single;
    request(0, 1'b1, 32'h0, 16'd4);
    #2;
    n_cmp++; if (bus.req_ready_o !== 2'b01) begin n_bad++; $display("FAIL ws_req_ready got=%b exp=01", bus.req_ready_o); end
    tick();
    bus.req_valid_i = '0;
    #2;
    n_cmp++; if ({bus.cfg_in_valid_o, bus.cfg_out_valid_o} !== 2'b10) begin n_bad++; $display("FAIL ws_cfg_valid got=%b exp=10", {bus.cfg_in_valid_o, bus.cfg_out_valid_o}); end
    tick();
    #2;
    n_cmp++; if (bus.cfg_in_valid_o !== 1'b1 || bus.cfg_in_addr_o !== 32'h0) begin n_bad++; $display("FAIL ws_cfg_hold got=%b/%0h exp=1/0", bus.cfg_in_valid_o, bus.cfg_in_addr_o); end
    bus.cfg_in_ready_i = 1'b1;
    tick();
    bus.cfg_in_ready_i = 1'b0;
    bus.ad_in_tready_i = 1'b1;
    bus.s_axis_tvalid_i = 2'b01;
    for (int i = 0; i < 4; i++) begin
      bus.s_axis_tdata_i = {32'h0, 32'hD0 + 32'(i)};
      #2;
      n_cmp++; if (bus.ad_in_tdata_o !== 32'hD0 + 32'(i)) begin n_bad++; $display("FAIL ws_data beat%0d got=%0h exp=%0h", i, bus.ad_in_tdata_o, 32'hD0 + 32'(i)); end
      n_cmp++; if (bus.ad_in_tlast_o !== (i == 3)) begin n_bad++; $display("FAIL ws_tlast beat%0d got=%b exp=%b", i, bus.ad_in_tlast_o, i == 3); end
      n_cmp++; if (bus.s_axis_tready_o !== 2'b01) begin n_bad++; $display("FAIL ws_tready beat%0d got=%b exp=01", i, bus.s_axis_tready_o); end
      tick();
    end
    bus.s_axis_tvalid_i = '0;
    bus.ad_in_tready_i = 1'b0;
    #2;
    n_cmp++; if (bus.done_o !== 2'b00) begin n_bad++; $display("FAIL ws_done_early got=%b exp=00", bus.done_o); end
    tick();
    #2;
    n_cmp++; if (bus.done_o !== 2'b01) begin n_bad++; $display("FAIL ws_done got=%b exp=01", bus.done_o); end
    tick();
    #2;
    n_cmp++; if (bus.done_o !== 2'b00) begin n_bad++; $display("FAIL ws_done_pulse got=%b exp=00", bus.done_o); end
  endtask
  task automatic test_write_split;
    logic [31:0] exp_a [3];
    int exp_n [3];
    int k, beat, cb, dn, nl;
    exp_a = '{32'h100, 32'h140, 32'h180};
    exp_n = '{16, 16, 8};
    k = 0; beat = 0; cb = 0; dn = 0; nl = 0;
    request(0, 1'b1, 32'h100, 16'd40);
    tick();
    bus.req_valid_i = '0;
    bus.cfg_in_ready_i = 1'b1; bus.ad_in_tready_i = 1'b1; bus.s_axis_tvalid_i = 2'b01;
    for (int cyc = 0; cyc < 300 && dn == 0; cyc++) begin
      bus.s_axis_tdata_i = {32'h0, 32'(beat)};
      #2;
      if (bus.cfg_in_valid_o) begin
        n_cmp++; if (k > 2 || bus.cfg_in_addr_o !== exp_a[k]) begin n_bad++; $display("FAIL split_cfg_addr chunk%0d got=%0h exp=%0h", k, bus.cfg_in_addr_o, exp_a[k]); end
        k++; cb = 0;
      end
      if (bus.ad_in_tvalid_o && bus.ad_in_tready_i) begin
        n_cmp++; if (bus.ad_in_tdata_o !== 32'(beat)) begin n_bad++; $display("FAIL split_data got=%0h exp=%0h", bus.ad_in_tdata_o, beat); end
        beat++; cb++;
        if (bus.ad_in_tlast_o) begin
          nl++;
          n_cmp++; if (k < 1 || cb !== exp_n[k-1]) begin n_bad++; $display("FAIL split_chunk_len got=%0d exp=%0d", cb, exp_n[k-1]); end
        end
      end
      if (bus.done_o !== 2'b00) begin
        dn++;
        n_cmp++; if (bus.done_o !== 2'b01) begin n_bad++; $display("FAIL split_done got=%b exp=01", bus.done_o); end
      end
      tick();
    end
    n_cmp++; if (beat !== 40 || k !== 3 || nl !== 3 || dn !== 1) begin n_bad++; $display("FAIL split_totals got=%0d/%0d/%0d/%0d exp=40/3/3/1", beat, k, nl, dn); end
    clear_inputs();
  endtask
  task automatic test_read_boundary;
    logic [31:0] exp_a [2];
    logic [31:0] exp_l [2];
    int k, beat, dn;
    exp_a = '{32'h3F8, 32'h400};
    exp_l = '{32'd1, 32'd3};
    k = 0; beat = 0; dn = 0;
    request(1, 1'b0, 32'h3F8, 16'd6);
    #2;
    n_cmp++; if (bus.req_ready_o !== 2'b10) begin n_bad++; $display("FAIL rb_req_ready got=%b exp=10", bus.req_ready_o); end
    tick();
    bus.req_valid_i = '0;
    bus.cfg_out_ready_i = 1'b1; bus.ad_out_tvalid_i = 1'b1; bus.m_axis_tready_i = 2'b10;
    for (int cyc = 0; cyc < 100 && dn == 0; cyc++) begin
      bus.ad_out_tdata_i = 32'hB0 + 32'(beat);
      #2;
      if (bus.cfg_out_valid_o) begin
        n_cmp++; if (k > 1 || bus.cfg_out_addr_o !== exp_a[k] || bus.cfg_out_length_o !== exp_l[k]) begin n_bad++; $display("FAIL rb_cfg chunk%0d got=%0h/%0d exp=%0h/%0d", k, bus.cfg_out_addr_o, bus.cfg_out_length_o, exp_a[k], exp_l[k]); end
        k++;
      end
      if (bus.ad_out_tready_o && bus.ad_out_tvalid_i) begin
        n_cmp++; if (bus.m_axis_tdata_o !== 32'hB0 + 32'(beat) || bus.m_axis_tvalid_o !== 2'b10) begin n_bad++; $display("FAIL rb_data got=%0h/%b exp=%0h/10", bus.m_axis_tdata_o, bus.m_axis_tvalid_o, 32'hB0 + 32'(beat)); end
        n_cmp++; if (bus.m_axis_tlast_o !== (beat == 5)) begin n_bad++; $display("FAIL rb_tlast beat%0d got=%b exp=%b", beat, bus.m_axis_tlast_o, beat == 5); end
        beat++;
      end
      if (bus.done_o !== 2'b00) begin
        dn++;
        n_cmp++; if (bus.done_o !== 2'b10) begin n_bad++; $display("FAIL rb_done got=%b exp=10", bus.done_o); end
      end
      tick();
    end
    n_cmp++; if (beat !== 6 || k !== 2 || dn !== 1) begin n_bad++; $display("FAIL rb_totals got=%0d/%0d/%0d exp=6/2/1", beat, k, dn); end
    clear_inputs();
  endtask
  task automatic test_read_toggle;
    int beat, dn;
    beat = 0; dn = 0;
    request(1, 1'b0, 32'h40, 16'd6);
    tick();
    bus.req_valid_i = '0;
    bus.cfg_out_ready_i = 1'b1; bus.ad_out_tvalid_i = 1'b1;
    for (int cyc = 0; cyc < 100 && dn == 0; cyc++) begin
      bus.ad_out_tdata_i = 32'hA0 + 32'(beat);
      bus.m_axis_tready_i = {cyc[0], 1'b0};
      #2;
      if (bus.m_axis_tvalid_o[1]) begin
        n_cmp++; if (bus.ad_out_tready_o !== cyc[0]) begin n_bad++; $display("FAIL tg_mirror got=%b exp=%b", bus.ad_out_tready_o, cyc[0]); end
      end
      if (bus.ad_out_tready_o && bus.ad_out_tvalid_i) begin
        n_cmp++; if (bus.m_axis_tdata_o !== 32'hA0 + 32'(beat)) begin n_bad++; $display("FAIL tg_data got=%0h exp=%0h", bus.m_axis_tdata_o, 32'hA0 + 32'(beat)); end
        beat++;
      end
      if (bus.done_o !== 2'b00) dn++;
      tick();
    end
    n_cmp++; if (beat !== 6 || dn !== 1) begin n_bad++; $display("FAIL tg_totals got=%0d/%0d exp=6/1", beat, dn); end
    clear_inputs();
  endtask
  task automatic test_len_zero;
    request(0, 1'b1, 32'h80, 16'd0);
    #2;
    n_cmp++; if (bus.req_ready_o !== 2'b01) begin n_bad++; $display("FAIL lz_req_ready got=%b exp=01", bus.req_ready_o); end
    tick();
    bus.req_valid_i = '0;
    bus.cfg_in_ready_i = 1'b1;
    #2;
    n_cmp++; if ({bus.cfg_in_valid_o, bus.cfg_out_valid_o} !== 2'b00) begin n_bad++; $display("FAIL lz_no_cfg got=%b exp=00", {bus.cfg_in_valid_o, bus.cfg_out_valid_o}); end
    n_cmp++; if (bus.done_o !== 2'b01) begin n_bad++; $display("FAIL lz_done got=%b exp=01", bus.done_o); end
    tick();
    #2;
    n_cmp++; if (bus.done_o !== 2'b00 || bus.cfg_in_valid_o !== 1'b0) begin n_bad++; $display("FAIL lz_after got=%b/%b exp=00/0", bus.done_o, bus.cfg_in_valid_o); end
    clear_inputs();
  endtask
  task automatic test_back_to_back;
    int ng, dn;
    logic cur;
    ng = 0; dn = 0; cur = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    request(0, 1'b1, 32'h10, 16'd2);
    request(1, 1'b1, 32'h20, 16'd2);
    bus.cfg_in_ready_i = 1'b1; bus.ad_in_tready_i = 1'b1; bus.s_axis_tvalid_i = 2'b11;
    bus.s_axis_tdata_i = {32'h1111, 32'h0000};
    for (int cyc = 0; cyc < 300 && dn < 4; cyc++) begin
      bus.req_valid_i = ng >= 4 ? 2'b00 : 2'b11;
      #2;
      if (bus.req_ready_o !== 2'b00) begin
        n_cmp++; if (bus.req_ready_o !== (ng[0] ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL bb_grant%0d got=%b exp=%b", ng, bus.req_ready_o, ng[0] ? 2'b10 : 2'b01); end
        cur = bus.req_ready_o[1];
        ng++;
      end
      if (bus.ad_in_tvalid_o) begin
        n_cmp++; if (bus.s_axis_tready_o !== {cur, ~cur}) begin n_bad++; $display("FAIL bb_tready got=%b exp=%b", bus.s_axis_tready_o, {cur, ~cur}); end
        n_cmp++; if (bus.ad_in_tdata_o !== (cur ? 32'h1111 : 32'h0)) begin n_bad++; $display("FAIL bb_mux got=%0h exp=%0h", bus.ad_in_tdata_o, cur ? 32'h1111 : 32'h0); end
      end
      n_cmp++; if (bus.m_axis_tvalid_o !== 2'b00) begin n_bad++; $display("FAIL bb_m_tvalid got=%b exp=00", bus.m_axis_tvalid_o); end
      if (bus.done_o !== 2'b00) begin
        dn++;
        n_cmp++; if (bus.done_o !== {cur, ~cur}) begin n_bad++; $display("FAIL bb_done got=%b exp=%b", bus.done_o, {cur, ~cur}); end
      end
      tick();
    end
    n_cmp++; if (ng !== 4 || dn !== 4) begin n_bad++; $display("FAIL bb_totals got=%0d/%0d exp=4/4", ng, dn); end
    clear_inputs();
  endtask
  task automatic test_reset_mid;
    int dn;
    dn = 0;
    request(0, 1'b1, 32'h0, 16'd4);
    tick();
    bus.req_valid_i = '0;
    bus.cfg_in_ready_i = 1'b1;
    tick();
    bus.cfg_in_ready_i = 1'b0;
    bus.ad_in_tready_i = 1'b1; bus.s_axis_tvalid_i = 2'b01;
    #2;
    n_cmp++; if (bus.ad_in_tvalid_o !== 1'b1) begin n_bad++; $display("FAIL rm_in_wdata got=%b exp=1", bus.ad_in_tvalid_o); end
    tick();
    rst_n = 1'b0;
    tick();
    #2;
    n_cmp++; if (all_out !== '0) begin n_bad++; $display("FAIL rm_outputs got=%0h exp=0", all_out); end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      #2;
      if (bus.done_o !== 2'b00) dn++;
    end
    n_cmp++; if (dn !== 0) begin n_bad++; $display("FAIL rm_no_done got=%0d exp=0", dn); end
    clear_inputs();
  endtask
  initial begin
    n_cmp = 0; n_bad = 0;
    test_reset();
    test_cke_hold();
    test_write_single();
    test_write_split();
    test_read_boundary();
    test_read_toggle();
    test_len_zero();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/iob_axis2ahb_sched.md
Name: iob_axis2ahb_sched

Overview:
Two-channel scheduler in front of the AXIS-to-AHB adapter. It arbitrates whole transfer requests between two requesters (round-robin) and splits each request into AHB-legal chunks: at most MAX_BURST beats, never crossing a 1 KB boundary. It issues one adapter config per chunk, muxes the granted channel's write stream in, and demuxes read data out. It pulses a per-channel done when a request completes.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, AXIS/AHB data width (power of 2, ≥8); BYTES=DATA_W/8
LEN_W, 16, request length field width (beats)
MAX_BURST, 16, max beats per chunk (power of 2, ≤ 1024/BYTES)

Ports:
clk_i  in  1  clock
cke_i  in  1  clock enable; all registers hold when 0
rst_n_i  in  1  reset, synchronous, active-low
req_valid_i  in  2  request valid, bit c = channel c
req_ready_o  out  2  request accepted (one-cycle, granted channel only)
req_write_i  in  2  1=write (AXIS→AHB), 0=read
req_addr_i  in  2*ADDR_W  start byte address; low log2(BYTES) bits forced 0
req_len_i  in  2*LEN_W  length in beats
done_o  out  2  one-cycle pulse when channel's request fully completes
s_axis_tdata_i  in  2*DATA_W  write data per channel
s_axis_tvalid_i  in  2  write data valid
s_axis_tready_o  out  2  write data ready (granted writing channel only)
m_axis_tdata_o  out  DATA_W  read data (shared)
m_axis_tvalid_o  out  2  read data valid (granted reading channel only)
m_axis_tready_i  in  2  read data ready
m_axis_tlast_o  out  1  last beat of whole request
cfg_in_valid_o / cfg_in_ready_i / cfg_in_addr_o  out/in/out  1/1/ADDR_W  adapter write config
cfg_out_valid_o / cfg_out_ready_i  out/in  1/1  adapter read config handshake
cfg_out_addr_o / cfg_out_length_o  out  ADDR_W/ADDR_W  read addr; length = chunk_beats-1
ad_in_tdata_o / ad_in_tvalid_o / ad_in_tlast_o / ad_in_tready_i  out/out/out/in  DATA_W/1/1/1  adapter write stream
ad_out_tdata_i / ad_out_tvalid_i / ad_out_tready_o  in/in/out  DATA_W/1/1  adapter read stream

Behaviour:
- Reset (rst_n_i=0 at clk edge, cke_i=1): state=IDLE, rr pointer=0 (ch0 first), all valid/ready/done/tlast outputs 0, addr/len/data outputs 0. Mid-transfer reset aborts immediately; no done issued.
- FSM: IDLE→ISSUE→(WDATA|RDATA)→NEXT→(ISSUE|DONE)→IDLE.
- IDLE: if any req_valid_i: grant = rr pointer channel if valid, else the other; pulse req_ready_o[grant]; latch write/addr/len; rr pointer=~grant. len=0: go straight to DONE (no config, no bus activity).
- Chunk size: chunk = min(remaining, MAX_BURST, (1024 - addr[9:0]) / BYTES); computed combinationally from registered addr/remaining, ≥1.
- ISSUE: write→cfg_in_valid_o=1, cfg_in_addr_o=addr; read→cfg_out_valid_o=1, addr, length=chunk-1. Held stable until ready; then →WDATA/RDATA, beat counter=chunk.
- WDATA: ad_in_* = s_axis_*[grant] pass-through (combinational, zero latency); s_axis_tready_o[grant]=ad_in_tready_i; ad_in_tlast_o=1 when counter==1. Each handshake decrements; last handshake→NEXT.
- RDATA: m_axis_tdata_o=ad_out_tdata_i, m_axis_tvalid_o[grant]=ad_out_tvalid_i, ad_out_tready_o=m_axis_tready_i[grant]; m_axis_tlast_o=1 when counter==1 and remaining==chunk. Last handshake→NEXT.
- NEXT (1 cycle): addr+=chunk*BYTES (mod 2^ADDR_W), remaining-=chunk; remaining==0→DONE else ISSUE.
- DONE (1 cycle): done_o[grant]=1, →IDLE. New request accepted no earlier than next IDLE cycle.
- Ungranted channel: all its ready/valid outputs 0; its requests wait (no drop).
- Simultaneous req_valid on both: rr pointer wins; alternation guaranteed under continuous contention.

Test Plan:
- ch0 write addr 0x0, len 4, MAX_BURST 16 → one cfg_in at 0x0, 4 beats, ad_in_tlast on beat 4, done_o[0] pulse 2 cycles after last beat.
- ch1 read addr 0x3F8, len 6, DATA_W 32 → cfg_out (0x3F8, len 1) then (0x400, len 3); 6 beats to m_axis ch1, m_axis_tlast only on beat 6.
- ch0 write len 40, addr 0x100 → chunks 16/16/8 at 0x100/0x140/0x180, tlast per chunk, single done.
- Both req_valid held continuously (len 2 each) → grants ch0,ch1,ch0,ch1; ungranted channel's tready/tvalid stay 0.
- Read with m_axis_tready_i[1] toggling 1/0 → ad_out_tready_o mirrors it; no beat lost/duplicated; data 0xA0..0xA5 in order.
- len 0 request → no cfg handshake, done pulse; rst_n_i low mid-WDATA → all outputs 0 next cycle, no done.
